// File: rtl/bcd_scan_display.sv
// Glitch-filtered BCD capture feeding a time-multiplexed 7-segment driver with
// leading-zero blanking, a one-cycle anti-ghost gap between digits and a sticky bad-digit flag.
module bcd_scan_display #(
  parameter int DIGITS     = 2,
  parameter int SCAN_DIV   = 4,
  parameter int STABLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  localparam logic GAP  = 1'b0;
  localparam logic SHOW = 1'b1;

  logic [4*DIGITS-1:0] s1, s2, disp;
  logic [CNT_W-1:0]    stab_cnt;
  logic                state;
  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;

  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic                any_bad;
  logic                all_zero;
  logic [6:0]          show_seg;
  logic [DIGITS-1:0]   an_onehot;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so the running all_zero chain works and no latch is inferred.
  always_comb begin
    all_zero  = 1'b1;
    any_bad   = 1'b0;
    blank_vec = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    // Walk from the most significant digit so all_zero covers digits i..DIGITS-1.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (disp[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_lz && (i != 0) && all_zero;
      any_bad      = any_bad | (disp[4*i +: 4] > 4'd9);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = disp[4*i +: 4];
        cur_blank = blank_vec[i];
      end
    end
    show_seg  = cur_blank ? 7'h00 : decode(cur_digit);
    an_onehot = DIGITS'(1) << idx;
  end

  // Two-flop sync of the whole bus, then accept only values seen unchanged long enough.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1       <= '0;
      s2       <= '0;
      stab_cnt <= '0;
      disp     <= '0;
      err      <= 1'b0;
    end else begin
      s1 <= bcd_in;
      s2 <= s1;
      if (s1 != s2)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_W'(STABLE_CYC))
        stab_cnt <= stab_cnt + 1'b1;
      if (stab_cnt == CNT_W'(STABLE_CYC))
        disp <= s2;
      if (any_bad)
        err <= 1'b1;
    end
  end

  // Scan: one dark GAP cycle, then SCAN_DIV lit cycles per digit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= GAP;
      pre   <= '0;
      idx   <= '0;
      an    <= '0;
      seg   <= 7'h00;
    end else if (state == GAP) begin
      state <= SHOW;
      pre   <= '0;
      an    <= an_onehot;
      seg   <= show_seg;
    end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
      state <= GAP;
      an    <= '0;
      seg   <= 7'h00;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
      seg <= show_seg;
    end
  end

endmodule
